// File: rtl/fifo_pack_reader.sv
// -----------------------------------------------------------------------------
// fifo_pack_reader
//
// Drain stage for the synchronous FIFO. Pops DATA_WIDTH words through the
// FIFO's fall-through read port and packs RATIO consecutive words into one
// wide beat on a valid/ready stream. Lane 0 holds the oldest word. A partial
// beat leaves on a flush pulse or, when FIFO_PACK_READER_TIMEOUT_EN is
// defined, after TIMEOUT consecutive idle cycles. Without that macro a partial
// beat waits for a flush indefinitely.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   fifo_read       pop strobe to the FIFO (combinational)
//   fifo_read_data  FIFO head word, valid while fifo_empty=0
//   fifo_empty      FIFO empty flag
//   flush           single-cycle request to emit the current partial beat
//   out_valid       beat valid (registered)
//   out_ready       downstream accept
//   out_data        packed beat, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   out_keep        lane-populated mask
// -----------------------------------------------------------------------------
module fifo_pack_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        fifo_read,
  input  logic [DATA_WIDTH-1:0]       fifo_read_data,
  input  logic                        fifo_empty,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep
);

  localparam int CW = $clog2(RATIO + 1);
  localparam int LW = $clog2(RATIO);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_OUTPUT  = 1'b1;

  generate
    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
      $error("fifo_pack_reader: RATIO must be a power of 2 and >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fifo_pack_reader: TIMEOUT must be >= 1");
    end
  endgenerate

  logic [0:0]                  r_state;
  logic [CW-1:0]               r_cnt;
  logic [DATA_WIDTH*RATIO-1:0] r_data;
  logic [RATIO-1:0]            r_keep;

  logic          w_pop;
  logic [CW-1:0] w_ncnt;
  logic [LW-1:0] w_lane;
  logic          w_timeout;
  logic          w_to_output;

  // While a beat is held, a pop is only allowed on the handshake cycle, so
  // the popped word can seed lane 0 of the next beat without a stall.
  assign w_pop  = ~fifo_empty & ((r_state == ST_COLLECT) | out_ready);
  assign w_ncnt = r_cnt + CW'(w_pop);
  // In COLLECT r_cnt < RATIO, so dropping the top bit is exact.
  assign w_lane = r_cnt[LW-1:0];

  assign w_to_output = (w_ncnt == CW'(RATIO))
                     | (flush & (w_ncnt != '0))
                     | w_timeout;

`ifdef FIFO_PACK_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_pop || r_cnt == '0 || r_state == ST_OUTPUT) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end

  // Fires on the TIMEOUT-th consecutive idle cycle after the last pop.
  assign w_timeout = (r_state == ST_COLLECT) & (r_cnt != '0) & ~w_pop
                   & (r_idle_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the lane registers are reset too; unpopulated lanes must read
      // as zero and nothing from before reset may leak into a later beat.
      r_state <= ST_COLLECT;
      r_cnt   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_pop) begin
            r_data[w_lane*DATA_WIDTH +: DATA_WIDTH] <= fifo_read_data;
            r_keep[w_lane]                          <= 1'b1;
          end
          r_cnt <= w_ncnt;
          if (w_to_output) begin
            r_state <= ST_OUTPUT;
          end
        end
        default: begin
          if (out_ready) begin
            r_state <= ST_COLLECT;
            if (w_pop) begin
              r_data <= (DATA_WIDTH*RATIO)'(fifo_read_data);
              r_keep <= RATIO'(1);
              r_cnt  <= CW'(1);
            end else begin
              r_data <= '0;
              r_keep <= '0;
              r_cnt  <= '0;
            end
          end
        end
      endcase
    end
  end

  assign fifo_read = w_pop;
  assign out_valid = r_state;
  assign out_data  = r_data;
  assign out_keep  = r_keep;

endmodule

// File: tb/tb_fifo_pack_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_pack_reader
//
// Self-checking bench for fifo_pack_reader (DATA_WIDTH=8, RATIO=4,
// TIMEOUT=16). The FIFO is a queue inside the bench. The reference model
// keeps the collected words in a queue and the pending beat as a flag plus
// packed value, applying the packing/flush/timeout rules each cycle.
// Directed scenarios come first, then randomized traffic. Timeout
// expectations follow FIFO_PACK_READER_TIMEOUT_EN as seen by this file.
// -----------------------------------------------------------------------------
module tb_fifo_pack_reader;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_read;
  logic [DW-1:0] fifo_read_data = '0;
  logic          fifo_empty = 1'b1;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW*R-1:0] out_data;
  logic [R-1:0]  out_keep;

  fifo_pack_reader #(.DATA_WIDTH(DW), .RATIO(R), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_read      (fifo_read),
    .fifo_read_data (fifo_read_data),
    .fifo_empty     (fifo_empty),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_keep       (out_keep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side FIFO contents and reference model state.
  logic [DW-1:0]   src[$];
  logic [DW-1:0]   words[$];
  bit              pend;
  logic [DW*R-1:0] beat_d;
  logic [R-1:0]    beat_k;
  int              idle;

  function automatic void model_clear();
    words.delete();
    pend   = 1'b0;
    beat_d = '0;
    beat_k = '0;
    idle   = 0;
  endfunction

  function automatic void pack_words();
    beat_d = '0;
    beat_k = '0;
    foreach (words[i]) begin
      beat_d[i*DW +: DW] = words[i];
      beat_k[i]          = 1'b1;
    end
    words.delete();
    pend = 1'b1;
  endfunction

  // One clock cycle; called and returns at a falling edge.
  task automatic cycle(input bit rdy, input bit fl);
    bit            pop;
    bit            fire;
    logic [DW-1:0] w;
    check("out_valid", out_valid, pend);
    if (pend) begin
      check("out_data", out_data, beat_d);
      check("out_keep", out_keep, beat_k);
    end
    out_ready      = rdy;
    flush          = fl;
    fifo_empty     = (src.size() == 0);
    fifo_read_data = (src.size() != 0) ? src[0] : DW'($urandom);
    pop            = !fifo_empty && (!pend || rdy);
    w              = fifo_read_data;
    #1;
    check("fifo_read", fifo_read, pop);
    @(posedge clk);
    if (pop) void'(src.pop_front());
    if (!pend) begin
      if (pop) words.push_back(w);
      fire = 1'b0;
`ifdef FIFO_PACK_READER_TIMEOUT_EN
      if (!pop && words.size() > 0) idle++;
      else                          idle = 0;
      fire = (idle == TO);
`endif
      if (words.size() == R || (fl && words.size() > 0) || fire) begin
        pack_words();
        idle = 0;
      end
    end else if (rdy) begin
      pend   = 1'b0;
      beat_d = '0;
      beat_k = '0;
      idle   = 0;
      if (pop) words.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic expect_beat(input string tag, input logic [DW*R-1:0] d, input logic [R-1:0] k);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_keep"}, out_keep, k);
  endtask

  // Called at a falling edge; leaves reset released at the next falling edge.
  task automatic do_reset();
    rst_n      = 1'b0;
    fifo_empty = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b0;
    src.delete();
    model_clear();
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_keep", out_keep, '0);
    check("rst_read", fifo_read, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [DW-1:0] first, input int n, input int stride);
    for (int i = 0; i < n; i++) src.push_back(DW'(first + DW'(i * stride)));
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Full beat.
    load(8'h11, 4, 8'h11);
    repeat (4) cycle(1'b1, 1'b0);
    expect_beat("full", 32'h44332211, 4'b1111);
    cycle(1'b1, 1'b0);

    // Backpressure, then release with same-cycle pop.
    load(8'h01, 8, 1);
    repeat (6) cycle(1'b0, 1'b0);
    expect_beat("bp_hold", 32'h04030201, 4'b1111);
    repeat (4) cycle(1'b1, 1'b0);
    expect_beat("bp_next", 32'h08070605, 4'b1111);
    cycle(1'b1, 1'b0);

    // Flush of a partial beat, then a flush with nothing held.
    load(8'hAA, 2, 8'h11);
    repeat (2) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    expect_beat("flush", 32'h0000BBAA, 4'b0011);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check("flush_empty_valid", out_valid, 1'b0);

    // Flush together with the 4th pop gives one full beat.
    load(8'h21, 4, 1);
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    expect_beat("flush_full", 32'h24232221, 4'b1111);
    cycle(1'b1, 1'b0);

    // Idle timeout.
    load(8'h01, 3, 1);
    repeat (3) cycle(1'b1, 1'b0);
`ifdef FIFO_PACK_READER_TIMEOUT_EN
    repeat (15) cycle(1'b1, 1'b0);
    check("to_early_valid", out_valid, 1'b0);
    cycle(1'b1, 1'b0);
    expect_beat("timeout", 32'h00030201, 4'b0111);
    cycle(1'b1, 1'b0);
`else
    repeat (100) cycle(1'b1, 1'b0);
    check("no_to_valid", out_valid, 1'b0);
    cycle(1'b1, 1'b1);
    expect_beat("late_flush", 32'h00030201, 4'b0111);
    cycle(1'b1, 1'b0);
`endif

    // Reset mid-beat discards collected words.
    load(8'hE0, 2, 1);
    repeat (2) cycle(1'b1, 1'b0);
    do_reset();
    load(8'h10, 4, 1);
    repeat (4) cycle(1'b1, 1'b0);
    expect_beat("post_rst", 32'h13121110, 4'b1111);
    cycle(1'b1, 1'b0);

    // Randomized traffic with random backpressure, flushes and fill gaps.
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = $urandom_range(0, 3);
      if (src.size() < 12 && k > 1) begin
        for (int j = 0; j < k - 1; j++) src.push_back(DW'($urandom));
      end
      cycle(($urandom_range(0, 3) != 0) || (n % 500 > 450),
            ($urandom_range(0, 15) == 0));
    end
    // Drain whatever is left.
    for (int n = 0; n < 64; n++) cycle(1'b1, (n % 8) == 7);
    check("drain_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pack_reader.md
# fifo_pack_reader

Downstream drain stage for the team's synchronous FIFO. It pops DATA_WIDTH words through the FIFO's fall-through read port and packs RATIO consecutive words into one wide beat. Beats are presented on a valid/ready output stream. Partial beats are emitted on an explicit flush and, optionally, after an idle timeout.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one FIFO word.
- RATIO, 4, words per output beat. Must be a power of 2 and ≥2; violation raises an elaboration-time $error.
- TIMEOUT, 16, consecutive idle cycles before a partial beat is flushed. Must be ≥1. Used only with the timeout macro.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fifo_read  out  1  pop strobe to the FIFO. Combinational.
- fifo_read_data  in  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- flush  in  1  single-cycle request to emit the current partial beat.
- out_valid  out  1  beat valid. Registered.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH*RATIO  packed beat. Lane i is bits [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 holds the oldest word.
- out_keep  out  RATIO  lane-valid mask, bit i set means lane i is populated.

## Operation
- Two states: COLLECT (out_valid=0) and OUTPUT (out_valid=1).
- State registers:
  - cnt, width $clog2(RATIO+1): words held.
  - idle_cnt, width $clog2(TIMEOUT+1): consecutive no-pop cycles.
  - the data and keep registers.
- pop = fifo_read, which means:
  - in COLLECT: pop = ~fifo_empty;
  - in OUTPUT: pop = out_ready & ~fifo_empty.
  - fifo_read is never 1 while fifo_empty=1.
- On a pop in COLLECT, fifo_read_data is written to lane cnt, out_keep[cnt] is set, and cnt increments.
- Let ncnt = cnt + pop. COLLECT → OUTPUT at the end of the cycle when any of these holds:
  - ncnt==RATIO;
  - flush=1 and ncnt>0;
  - timeout fires.
- A flush with ncnt==0 is ignored and not remembered. A flush while in OUTPUT is ignored.
- OUTPUT holds out_data, out_keep and out_valid stable until out_valid&out_ready.
- On the handshake cycle:
  - data and keep clear;
  - if pop=1 that same cycle, the popped word is loaded into lane 0, with cnt=1 and keep=1;
  - otherwise cnt=0;
  - the next state is COLLECT.
- Lanes with out_keep=0 read as zero.
- Throughput: one full beat per RATIO cycles with continuous data and out_ready=1.

## Timing
- Reset values: state COLLECT, cnt=0, idle_cnt=0, out_valid=0, out_data=0, out_keep=0.
- fifo_read follows fifo_empty, which the FIFO holds high in reset.
- Reset mid-beat discards all collected words; nothing is emitted afterwards.
- Latency: out_valid rises on the clock edge that captures the RATIO-th pop, so it is visible in the next cycle.
- The path out_ready → fifo_read is combinational. Upstream FIFO read_data is combinational from its read pointer; no register is needed on the input.
- Timeout (macro defined):
  - idle_cnt clears on a pop or whenever cnt==0;
  - otherwise it increments in COLLECT;
  - fire condition is COLLECT, cnt>0, pop=0 and idle_cnt==TIMEOUT-1;
  - so the edge ending the TIMEOUT-th idle cycle after the last pop sets out_valid.
- Simultaneous flush and RATIO-th pop gives one full beat, keep all ones.

## Configuration
- FIFO_PACK_READER_TIMEOUT_EN:
  - Defined: the idle timeout flush is implemented as above.
  - Undefined: idle_cnt is not built, TIMEOUT is ignored, and partial beats leave only via flush. A partial beat with no flush waits indefinitely.

## Test plan
All scenarios use DATA_WIDTH=8, RATIO=4, TIMEOUT=16.
- **Full beat:** FIFO holds 0x11,0x22,0x33,0x44 and out_ready=1 → fifo_read high 4 consecutive cycles; next cycle out_valid=1, out_data=0x44332211, out_keep=4'b1111.
- **Backpressure:** FIFO holds 0x01..0x08 and out_ready=0 → 4 pops, then fifo_read=0 with out_data=0x04030201 stable; raise out_ready → fifo_read=1 in the same cycle; next beat is 0x08070605.
- **Flush:** FIFO gets 0xAA,0xBB, then a flush pulse → out_data=0x0000BBAA, out_keep=4'b0011. A flush with cnt=0 and FIFO empty → out_valid stays 0.
- **Timeout, macro defined:** 3 words 0x01,0x02,0x03 then FIFO empty → out_valid rises at the edge ending the 16th idle cycle, out_keep=4'b0111. Macro undefined → out_valid stays 0 for 100 cycles.
- **Reset mid-operation:** 2 words collected, then rst_n low for 1 cycle → all outputs 0 immediately. Next 4 words 0x10..0x13 → out_data=0x13121110, keep=4'b1111, no residue from before reset.
